// File: rtl/seu_readout_arbiter.sv
// SEU readout arbiter: round-robin share of one FIFO write port
// among N error-event channels, with periodic timestamp words.
module seu_readout_arbiter #(
  parameter int N         = 8,
  parameter int PAYLOAD_W = 28,
  parameter int TS_SHIFT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N-1:0]           ch_req,
  input  logic [N*PAYLOAD_W-1:0] ch_data,
  output logic [N-1:0]           ch_ack,
  input  logic                   fifo_full,
  output logic [31:0]            fifo_din,
  output logic                   fifo_wr_en,
  output logic [15:0]            ts_missed,
  output logic                   busy
);

  logic [27:0]  timer_q, timer_d, timer_inc;
  logic         ts_pending_q, ts_pending_d;
  logic [15:0]  missed_q, missed_d;
  logic [3:0]   last_q, last_d;
  logic [N-1:0] ack_q, ack_d;
  logic [31:0]  din_q, din_d;
  logic         wr_q, wr_d;

  logic         wrap, decide, ts_req, ts_served;
  logic         found;
  logic [3:0]   gnt;
  logic [N-1:0] elig;
  int           j;

  // Round-robin search for the next eligible channel after last_q.
  always_comb begin
    elig  = ch_req & ~ack_q;
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_q) + k) % N;
      if (!found && elig[j]) begin
        found = 1'b1;
        gnt   = 4'(j);
      end
    end
  end

  // Timer, timestamp bookkeeping and the per-cycle grant decision.
  // A wrap seen while the port is free is written on that same edge,
  // so the word carries the timer value just before the wrap.
  always_comb begin
    timer_inc    = timer_q + 28'd1;
    wrap         = enable && (timer_inc[TS_SHIFT-1:0] == '0);
    timer_d      = enable ? timer_inc : timer_q;
    decide       = enable && !fifo_full;
    ts_req       = ts_pending_q || wrap;
    ts_served    = 1'b0;
    ack_d        = '0;
    wr_d         = 1'b0;
    din_d        = din_q;
    last_d       = last_q;
    missed_d     = missed_q;
    if (decide) begin
      if (ts_req) begin
        din_d     = {4'hF, timer_q};
        wr_d      = 1'b1;
        ts_served = 1'b1;
      end else if (found) begin
        ack_d  = N'(1) << gnt;
        din_d  = {gnt, ch_data[int'(gnt)*PAYLOAD_W +: PAYLOAD_W]};
        wr_d   = 1'b1;
        last_d = gnt;
      end
    end
    if (ts_served)
      ts_pending_d = ts_pending_q && wrap;
    else
      ts_pending_d = ts_pending_q || wrap;
    if (!ts_served && ts_pending_q && wrap && (missed_q != 16'hFFFF))
      missed_d = missed_q + 16'd1;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q      <= '0;
      ts_pending_q <= 1'b0;
      missed_q     <= '0;
      last_q       <= 4'(N-1);
      ack_q        <= '0;
      din_q        <= '0;
      wr_q         <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      ts_pending_q <= ts_pending_d;
      missed_q     <= missed_d;
      last_q       <= last_d;
      ack_q        <= ack_d;
      din_q        <= din_d;
      wr_q         <= wr_d;
    end
  end

  assign ch_ack     = ack_q;
  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;
  assign ts_missed  = missed_q;
  assign busy       = wr_q | (enable & ((|ch_req) | ts_pending_q));

endmodule

// File: doc/seu_readout_arbiter.md
Name: seu_readout_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit readout FIFO write port among N per-channel PRBS31 error-event sources (6 Rx + 1 Tx + spare in the GBCR2 SEU setup).
- Periodically inserts a timestamp word at the highest priority so that the host can align error bursts in time.
- Sits between the per-channel checker logic and the readout FIFO; the FIFO read side (fifo_rd_clk) is outside this block.

Parameters:
- N, 8, number of requesting channels (1..15).
- PAYLOAD_W, 28, payload bits per channel word (fixed: 32 - 4-bit tag).
- TS_SHIFT, 16, timestamp word emitted each time timer[TS_SHIFT-1:0] wraps to 0.

Ports:
- clk  in  1  single block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = grants allowed; 0 = stop granting and stop timestamps.
- ch_req  in  N  channel i holds 1 while a word is pending.
- ch_data  in  N*PAYLOAD_W  channel i payload at bits [i*28 +: 28]; held stable while ch_req[i]=1.
- ch_ack  out  N  one-cycle pulse: channel i word accepted.
- fifo_full  in  1  FIFO almost-full; programmed at least 1 word below the true full level.
- fifo_din  out  32  word to the FIFO.
- fifo_wr_en  out  1  write strobe, one cycle per word.
- ts_missed  out  16  count of timestamp slots dropped, saturating.
- busy  out  1  1 while any grant or write is in flight.

Behaviour:
- Reset values: ch_ack=0, fifo_din=0, fifo_wr_en=0, ts_missed=0, busy=0, timer=0, last_grant=N-1, ts_pending=0.
- timer: 28-bit free-running counter, increments every cycle while enable=1, wraps modulo 2^28.
- ts_pending: set when enable=1 and the incremented value of timer has bits [TS_SHIFT-1:0]=0.
  - If ts_pending is already 1 when a new wrap occurs, ts_pending stays 1 and ts_missed increments (saturates at 16'hFFFF).
- Decision: evaluated every cycle when enable=1 and fifo_full=0.
  - Priority 1: if ts_pending=1, register fifo_din={4'hF, timer} and fifo_wr_en=1, then clear ts_pending. No ch_ack that cycle.
  - Priority 2: otherwise use the eligible request vector, ch_req & ~ch_ack (the mask stops a channel being granted again in its ack cycle).
    - Search round-robin starting at last_grant+1 and wrapping at N.
    - For the first set index g, register ch_ack[g]=1, fifo_din={g[3:0], ch_data[g]}, fifo_wr_en=1, last_grant=g.
  - Nothing eligible: fifo_wr_en=0, ch_ack=0.
- Latency: request to ack/write is 1 cycle (registered outputs). ch_ack and fifo_wr_en for a channel word are asserted in the same cycle.
- Requester rule: ch_data is sampled on the decision edge. After the ack cycle the requester either drops ch_req or presents its next word.
- Throughput: at most 1 word per cycle. One channel with req held continuously gets a word every 2nd cycle because of the mask. Any other channel fills the gap cycles.
- Fairness: with all N channels requesting continuously, each channel is granted exactly once per N channel grants.
- Backpressure:
  - fifo_full=1: no decision that cycle, fifo_wr_en=0 next cycle, and requests are held.
  - fifo_full rising in the same cycle as a registered write still lets that write complete (covered by the 1-word margin).
- enable=0: no new decisions, and timer and ts_pending are frozen. A write already registered completes.
- busy = fifo_wr_en | (enable & (|ch_req | ts_pending)).
- Reset mid-operation: all state returns to reset values on the next edge. Pending requests are re-arbitrated from channel 0 after reset.
- Channel tag 4'hF is reserved for timestamp words; N must not exceed 15.

Test Plan:
- Reset, enable=1, ch_req=8'h01, ch_data[0]=28'h0ABCDEF for 1 cycle then dropped -> one cycle later ch_ack=8'h01, fifo_din=32'h00ABCDEF, fifo_wr_en=1 for exactly 1 cycle.
- All 8 ch_req held high, fifo_full=0 for 16 cycles -> grant order 0,1,...,7,0,...; each channel tag appears twice in the writes; no tag appears in two consecutive writes.
- TS_SHIFT=4 build, enable=1, no requests -> a timestamp word 32'hF000000F is written at cycle 16 after reset release, then one every 16 cycles (tags all 4'hF).
- TS_SHIFT=4, channel requests saturating and fifo_full=1 for 40 cycles -> no writes during the window; ts_missed=1 (the 2nd wrap is dropped while ts_pending=1); after release the first write is a timestamp word.
- Requests active, then fifo_full pulses high for 3 cycles -> fifo_wr_en=0 for the 3 following cycles; no ch_ack is lost and the order resumes from last_grant+1.
- Reset asserted while ch_req=8'hFF -> outputs and ts_missed are 0 the next cycle; the first grant after release goes to channel 0.
